spi_access_arbiter: RTL and testbench
=====================================

# spi_access_arbiter

Shares the single SPI register-access master between two requesters: requester 0 is the UART command controller, requester 1 is the autonomous register init/poll sequencer. It grants one transaction at a time, round-robin between the two. It drives the master's start/rw/address/data controls and waits for the master's completion pulse, with a timeout watchdog. It returns read data and completion/error status to the granted requester.

## Interface
- SPI_ADDR_WIDTH, 6, SPI register address width
- SPI_DATA_WIDTH, 20, SPI register data width
- TIMEOUT_CYCLES, 1023, max WAIT cycles before a transaction is aborted with error (≥2)
- i_clk_sys  input  1  system clock; all logic on rising edge
- i_rst  input  1  reset; synchronous, active-high
- i_req[1:0]  input  2  per-requester request level; held until matching o_ack
- i_rw0 / i_rw1  input  1  0 = write, 1 = read
- i_addr0 / i_addr1  input  SPI_ADDR_WIDTH  register address
- i_wdata0 / i_wdata1  input  SPI_DATA_WIDTH  write data
- o_ack[1:0]  output  2  one-cycle pulse: request accepted, command latched
- o_done[1:0]  output  2  one-cycle pulse: transaction finished
- o_err  output  1  valid with o_done; 1 = timeout
- o_rdata  output  SPI_DATA_WIDTH  read result, valid with o_done of a read
- o_busy  output  1  high in any state other than IDLE
- o_spi_start  output  1  one-cycle start pulse to SPI master
- o_spi_rw  output  1  latched rw to master
- o_spi_write_address  output  SPI_ADDR_WIDTH  latched address
- o_spi_write_data  output  SPI_DATA_WIDTH  latched write data
- i_spi_data_valid  input  1  master completion pulse (read data valid for reads)
- i_spi_read_data  input  SPI_DATA_WIDTH  master read data

## Operation
- States: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE, with i_req != 0:
  - Pick the winner: a single request wins; if both request, the winner is the requester not equal to last_gnt.
  - Load o_spi_rw/address/data from the winner's inputs.
  - Set o_spi_start=1 and o_ack[winner]=1; record gnt=winner and last_gnt=winner.
  - Go to ISSUE.
- ISSUE: clear o_spi_start and o_ack; clear the timer; go to WAIT.
- WAIT, i_spi_data_valid=1:
  - o_done[gnt]=1, o_err=0.
  - For a read, o_rdata<=i_spi_read_data; for a write, o_rdata is unchanged.
  - Go to DONE.
- WAIT, no valid and timer==TIMEOUT_CYCLES-1: o_done[gnt]=1, o_err=1, o_rdata<=0; go to DONE.
- WAIT, otherwise: timer+1. Timer width is clog2(TIMEOUT_CYCLES).
- DONE: clear o_done and o_err; go to IDLE. Requests are not sampled in DONE.
- i_spi_data_valid outside WAIT is ignored, including a stray pulse in ISSUE. A master completion is only accepted at least one cycle after start.
- Request changes after o_ack do not affect the latched command.
- A requester still asserting i_req in IDLE after its o_done is treated as a new request.
- Reset values:
  - state=IDLE, last_gnt=1 (requester 0 wins the first tie), gnt=0, timer=0.
  - o_ack=0, o_done=0, o_err=0, o_rdata=0, o_busy=0.
  - o_spi_start=0, o_spi_rw=0, o_spi_write_address=0, o_spi_write_data=0.
- Reset asserted mid-transaction aborts immediately to the reset values. No o_done is issued; the SPI master is reset by the same i_rst.

## Timing
- Edge N samples i_req in IDLE. In cycle N+1, o_spi_start, o_ack and the latched command are high/valid, and o_busy=1.
- In cycle N+2 the block is in WAIT, with o_spi_start=0.
- i_spi_data_valid sampled at edge M in WAIT gives o_done/o_rdata during cycle M+1 (DONE). The block is in IDLE at M+2.
- Earliest next grant: o_ack at M+3. Back-to-back throughput is master latency + 3 cycles.
- Timeout: o_done/o_err are asserted TIMEOUT_CYCLES+1 cycles after the o_spi_start cycle.
- o_ack and o_done are exactly one cycle wide, and never both high in the same cycle.

## Test plan
- Single write:
  - Stimulus: req0, rw0=0, addr0=6'h15, wdata0=20'hABCDE; master returns valid 8 cycles after start.
  - Required: one start pulse with address 15h and data ABCDEh; ack0, then done0 with err=0; o_rdata unchanged.
- Single read:
  - Stimulus: req1, rw1=1, addr1=6'h3F; master returns 20'h12345.
  - Required: done1 with o_rdata=12345h; o_done[0] never pulses.
- Simultaneous requests after reset:
  - Stimulus: i_req=2'b11 held until each ack.
  - Required: grant order 0,1,0,1 over four transactions; exactly one start per ack; next ack exactly 3 cycles after each valid.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=16, read request, master never responds.
  - Required: done with err=1 and o_rdata=0, 17 cycles after start; the next request is serviced normally.
- Stray valid and request change:
  - Stimulus: valid pulse in IDLE and in ISSUE; addr0 changed the cycle after ack.
  - Required: both pulses ignored; the master sees the originally latched address; completion only on the later WAIT valid.
- Reset mid-WAIT:
  - Stimulus: assert i_rst for 1 cycle during WAIT.
  - Required: all outputs at reset values the next cycle; no done; a subsequent tie grants requester 0.

Source files
------------

// File: rtl/spi_access_arbiter.sv
// rtl/spi_access_arbiter.sv - round-robin arbiter sharing one SPI register-access master between two requesters
module spi_access_arbiter #(
  parameter int SPI_ADDR_WIDTH = 6,
  parameter int SPI_DATA_WIDTH = 20,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                      i_clk_sys,
  input  logic                      i_rst,
  input  logic [1:0]                i_req,
  input  logic                      i_rw0,
  input  logic                      i_rw1,
  input  logic [SPI_ADDR_WIDTH-1:0] i_addr0,
  input  logic [SPI_ADDR_WIDTH-1:0] i_addr1,
  input  logic [SPI_DATA_WIDTH-1:0] i_wdata0,
  input  logic [SPI_DATA_WIDTH-1:0] i_wdata1,
  output logic [1:0]                o_ack,
  output logic [1:0]                o_done,
  output logic                      o_err,
  output logic [SPI_DATA_WIDTH-1:0] o_rdata,
  output logic                      o_busy,
  output logic                      o_spi_start,
  output logic                      o_spi_rw,
  output logic [SPI_ADDR_WIDTH-1:0] o_spi_write_address,
  output logic [SPI_DATA_WIDTH-1:0] o_spi_write_data,
  input  logic                      i_spi_data_valid,
  input  logic [SPI_DATA_WIDTH-1:0] i_spi_read_data
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                    state, state_nx;
  logic                      gnt, gnt_nx;
  logic                      last_gnt, last_gnt_nx;
  logic                      winner;
  logic [TIMER_W-1:0]        timer, timer_nx;
  logic [1:0]                ack_nx, done_nx;
  logic                      err_nx, busy_nx, start_nx, rw_nx;
  logic [SPI_DATA_WIDTH-1:0] rdata_nx, wdata_nx;
  logic [SPI_ADDR_WIDTH-1:0] addr_nx;

  // On a tie the requester that did not win last time takes the grant.
  assign winner = (i_req == 2'b11) ? ~last_gnt : i_req[1];

  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      state               <= S_IDLE;
      gnt                 <= 1'b0;
      last_gnt            <= 1'b1;
      timer               <= '0;
      o_ack               <= 2'b00;
      o_done              <= 2'b00;
      o_err               <= 1'b0;
      o_rdata             <= '0;
      o_busy              <= 1'b0;
      o_spi_start         <= 1'b0;
      o_spi_rw            <= 1'b0;
      o_spi_write_address <= '0;
      o_spi_write_data    <= '0;
    end else begin
      state               <= state_nx;
      gnt                 <= gnt_nx;
      last_gnt            <= last_gnt_nx;
      timer               <= timer_nx;
      o_ack               <= ack_nx;
      o_done              <= done_nx;
      o_err               <= err_nx;
      o_rdata             <= rdata_nx;
      o_busy              <= busy_nx;
      o_spi_start         <= start_nx;
      o_spi_rw            <= rw_nx;
      o_spi_write_address <= addr_nx;
      o_spi_write_data    <= wdata_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    gnt_nx      = gnt;
    last_gnt_nx = last_gnt;
    timer_nx    = timer;
    ack_nx      = 2'b00;
    done_nx     = 2'b00;
    err_nx      = 1'b0;
    start_nx    = 1'b0;
    rdata_nx    = o_rdata;
    rw_nx       = o_spi_rw;
    addr_nx     = o_spi_write_address;
    wdata_nx    = o_spi_write_data;
    case (state)
      S_IDLE: begin
        if (i_req != 2'b00) begin
          gnt_nx         = winner;
          last_gnt_nx    = winner;
          ack_nx[winner] = 1'b1;
          start_nx       = 1'b1;
          rw_nx          = winner ? i_rw1 : i_rw0;
          addr_nx        = winner ? i_addr1 : i_addr0;
          wdata_nx       = winner ? i_wdata1 : i_wdata0;
          state_nx       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_nx = '0;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (i_spi_data_valid) begin
          done_nx[gnt] = 1'b1;
          if (o_spi_rw) rdata_nx = i_spi_read_data;
          state_nx = S_DONE;
        end else if (timer == TIMER_LAST) begin
          done_nx[gnt] = 1'b1;
          err_nx       = 1'b1;
          rdata_nx     = '0;
          state_nx     = S_DONE;
        end else begin
          timer_nx = timer + TIMER_W'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase
    busy_nx = (state_nx != S_IDLE);
  end

endmodule

// File: tb/tb_spi_access_arbiter.sv
// tb/tb_spi_access_arbiter.sv - self-checking bench for spi_access_arbiter
module tb_spi_access_arbiter;
  localparam int AW = 6;
  localparam int DW = 20;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req;
  logic          rw0, rw1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [1:0]    ack, done;
  logic          err, busy, spi_start, spi_rw, spi_valid;
  logic [DW-1:0] rdata, spi_wdata, spi_rdata;
  logic [AW-1:0] spi_addr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic          model_last;
  logic [DW-1:0] model_rdata;

  int            n_start, n_ack, n_done, s_cyc, ack_cyc, done_cyc, valid_cyc;
  logic [1:0]    ack_val, done_val;
  logic          s_rw, s_busy, err_o, overlap;
  logic [AW-1:0] s_addr, done_addr;
  logic [DW-1:0] s_data, rdata_o;

  always #5 clk = ~clk;

  spi_access_arbiter #(
    .SPI_ADDR_WIDTH(AW),
    .SPI_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk_sys(clk),
    .i_rst(rst),
    .i_req(req),
    .i_rw0(rw0),
    .i_rw1(rw1),
    .i_addr0(addr0),
    .i_addr1(addr1),
    .i_wdata0(wdata0),
    .i_wdata1(wdata1),
    .o_ack(ack),
    .o_done(done),
    .o_err(err),
    .o_rdata(rdata),
    .o_busy(busy),
    .o_spi_start(spi_start),
    .o_spi_rw(spi_rw),
    .o_spi_write_address(spi_addr),
    .o_spi_write_data(spi_wdata),
    .i_spi_data_valid(spi_valid),
    .i_spi_read_data(spi_rdata)
  );

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drives one request set, plays the SPI master (valid lat cycles after start) and records what it saw.
  task automatic run_txn(input logic [1:0] rq, input int lat, input logic respond,
                         input logic [DW-1:0] rd, input logic scramble);
    n_start = 0; n_ack = 0; n_done = 0;
    s_cyc = -1; ack_cyc = -1; done_cyc = -1; valid_cyc = -1;
    ack_val = 2'b00; done_val = 2'b00; overlap = 1'b0;
    spi_rdata = rd;
    req = rq;
    for (int c = 0; c < 60 && n_done == 0; c++) begin
      tick();
      spi_valid = 1'b0;
      if (ack != 2'b00 && done != 2'b00) overlap = 1'b1;
      if (spi_start) begin
        n_start++; s_cyc = cyc; s_rw = spi_rw; s_addr = spi_addr; s_data = spi_wdata; s_busy = busy;
      end
      if (ack != 2'b00) begin
        n_ack++; ack_cyc = cyc; ack_val = ack;
        req = req & ~ack;
        if (scramble) begin
          rw0 = 1'($urandom); rw1 = 1'($urandom);
          addr0 = AW'($urandom); addr1 = AW'($urandom);
          wdata0 = DW'($urandom); wdata1 = DW'($urandom);
        end
      end
      if (done != 2'b00) begin
        n_done++; done_cyc = cyc; done_val = done; err_o = err; rdata_o = rdata; done_addr = spi_addr;
      end
      if (respond && s_cyc >= 0 && cyc == s_cyc + lat) begin
        spi_valid = 1'b1;
        valid_cyc = cyc;
      end
    end
    spi_valid = 1'b0;
    checks++;
    if (n_done !== 1) begin
      failures++; $display("FAIL txn_completed got=%0d exp=1", n_done);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({ack, done, err, rdata, busy, spi_start, spi_rw, spi_addr, spi_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got ack=%b done=%b err=%b rdata=%h busy=%b start=%b rw=%b addr=%h wdata=%h exp all zero",
               ack, done, err, rdata, busy, spi_start, spi_rw, spi_addr, spi_wdata);
    end
    rst = 1'b0;
    model_last = 1'b1;
    model_rdata = '0;
  endtask

  task automatic test_single_write;
    rw0 = 1'b0; addr0 = 6'h15; wdata0 = 20'hABCDE;
    run_txn(2'b01, 8, 1'b1, 20'h55555, 1'b0);
    checks++; if (n_start !== 1) begin failures++; $display("FAIL wr_start_count got=%0d exp=1", n_start); end
    checks++; if (s_addr !== 6'h15) begin failures++; $display("FAIL wr_addr got=%h exp=15", s_addr); end
    checks++; if (s_data !== 20'hABCDE) begin failures++; $display("FAIL wr_data got=%h exp=abcde", s_data); end
    checks++; if (s_rw !== 1'b0) begin failures++; $display("FAIL wr_rw got=%b exp=0", s_rw); end
    checks++; if (s_busy !== 1'b1) begin failures++; $display("FAIL wr_busy got=%b exp=1", s_busy); end
    checks++; if (ack_val !== 2'b01 || ack_cyc !== s_cyc) begin failures++; $display("FAIL wr_ack got=%b@%0d exp=01@%0d", ack_val, ack_cyc, s_cyc); end
    checks++; if (done_val !== 2'b01 || err_o !== 1'b0) begin failures++; $display("FAIL wr_done got=%b err=%b exp=01 err=0", done_val, err_o); end
    checks++; if (rdata_o !== model_rdata) begin failures++; $display("FAIL wr_rdata got=%h exp=%h", rdata_o, model_rdata); end
    checks++; if (done_cyc !== s_cyc + 9) begin failures++; $display("FAIL wr_latency got=%0d exp=%0d", done_cyc - s_cyc, 9); end
    model_last = 1'b0;
  endtask

  task automatic test_single_read;
    rw1 = 1'b1; addr1 = 6'h3F; wdata1 = 20'h00000;
    run_txn(2'b10, 5, 1'b1, 20'h12345, 1'b0);
    checks++; if (s_addr !== 6'h3F || s_rw !== 1'b1) begin failures++; $display("FAIL rd_cmd got=%h/%b exp=3f/1", s_addr, s_rw); end
    checks++; if (done_val !== 2'b10) begin failures++; $display("FAIL rd_done got=%b exp=10", done_val); end
    checks++; if (rdata_o !== 20'h12345 || err_o !== 1'b0) begin failures++; $display("FAIL rd_rdata got=%h err=%b exp=12345 err=0", rdata_o, err_o); end
    model_last = 1'b1;
    model_rdata = 20'h12345;
  endtask

  task automatic test_timeout;
    rw0 = 1'b1; addr0 = 6'h2C;
    run_txn(2'b01, 0, 1'b0, 20'hFFFFF, 1'b0);
    checks++; if (done_val !== 2'b01 || err_o !== 1'b1) begin failures++; $display("FAIL to_done got=%b err=%b exp=01 err=1", done_val, err_o); end
    checks++; if (rdata_o !== 20'h0) begin failures++; $display("FAIL to_rdata got=%h exp=0", rdata_o); end
    checks++; if (done_cyc !== s_cyc + TO + 1) begin failures++; $display("FAIL to_latency got=%0d exp=%0d", done_cyc - s_cyc, TO + 1); end
    model_last = 1'b0;
    rw1 = 1'b1; addr1 = 6'h07;
    run_txn(2'b10, 4, 1'b1, 20'h0BEEF, 1'b0);
    checks++; if (done_val !== 2'b10 || err_o !== 1'b0 || rdata_o !== 20'h0BEEF) begin
      failures++; $display("FAIL to_recover got=%b err=%b rdata=%h exp=10 err=0 rdata=0beef", done_val, err_o, rdata_o);
    end
    model_last = 1'b1;
    model_rdata = 20'h0BEEF;
  endtask

  task automatic test_back_to_back;
    int prev_valid;
    logic exp_w;
    rst = 1'b1; tick(); rst = 1'b0;
    model_last = 1'b1; model_rdata = '0;
    rw0 = 1'b0; rw1 = 1'b0; addr0 = 6'h01; addr1 = 6'h02;
    prev_valid = -1;
    for (int i = 0; i < 4; i++) begin
      exp_w = ~model_last;
      run_txn(2'b11, 2 + i, 1'b1, 20'h0, 1'b0);
      checks++; if (ack_val !== (2'b01 << exp_w) || n_ack !== 1 || n_start !== 1) begin
        failures++; $display("FAIL b2b_grant%0d got=%b acks=%0d starts=%0d exp=%b 1 1", i, ack_val, n_ack, n_start, 2'b01 << exp_w);
      end
      if (i > 0) begin
        checks++; if (ack_cyc !== prev_valid + 3) begin failures++; $display("FAIL b2b_gap%0d got=%0d exp=3", i, ack_cyc - prev_valid); end
      end
      prev_valid = valid_cyc;
      model_last = exp_w;
    end
  endtask

  task automatic test_stray_valid;
    logic bad;
    req = 2'b00;
    spi_valid = 1'b1; tick(); spi_valid = 1'b0;
    checks++; if (done !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL stray_idle got done=%b busy=%b exp=00 0", done, busy); end
    rw0 = 1'b0; addr0 = 6'h2A; wdata0 = 20'h13579; req = 2'b01;
    for (int c = 0; c < 10 && ack == 2'b00; c++) tick();
    checks++; if (ack !== 2'b01) begin failures++; $display("FAIL stray_ack got=%b exp=01", ack); end
    spi_valid = 1'b1; addr0 = 6'h11; req = 2'b00;
    tick(); spi_valid = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (done !== 2'b00 || spi_addr !== 6'h2A) bad = 1'b1;
      tick();
    end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL stray_ignored got=%b exp=0", bad); end
    spi_valid = 1'b1; tick(); spi_valid = 1'b0;
    checks++; if (done !== 2'b01 || err !== 1'b0 || spi_addr !== 6'h2A) begin
      failures++; $display("FAIL stray_done got=%b err=%b addr=%h exp=01 0 2a", done, err, spi_addr);
    end
    tick();
    model_last = 1'b0;
  endtask

  task automatic test_reset_mid_wait;
    logic bad;
    rw0 = 1'b0; addr0 = 6'h0F; req = 2'b01;
    for (int c = 0; c < 10 && ack == 2'b00; c++) tick();
    req = 2'b00;
    tick(); tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if ({ack, done, err, rdata, busy, spi_start, spi_rw, spi_addr, spi_wdata} !== '0) begin
      failures++; $display("FAIL midrst_outputs got ack=%b done=%b err=%b rdata=%h busy=%b start=%b exp all zero",
                           ack, done, err, rdata, busy, spi_start);
    end
    bad = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done !== 2'b00 || ack !== 2'b00) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL midrst_quiet got=%b exp=0", bad); end
    model_last = 1'b1; model_rdata = '0;
    run_txn(2'b11, 3, 1'b1, 20'h0, 1'b0);
    checks++; if (ack_val !== 2'b01) begin failures++; $display("FAIL midrst_tie got=%b exp=01", ack_val); end
    model_last = 1'b0;
  endtask

  task automatic test_random;
    logic [1:0]    rq;
    logic          exp_w, exp_rw;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data, rd, exp_rdata;
    int            lat;
    for (int i = 0; i < 20; i++) begin
      rq = 2'($urandom_range(1, 3));
      rw0 = 1'($urandom); rw1 = 1'($urandom);
      addr0 = AW'($urandom); addr1 = AW'($urandom);
      wdata0 = DW'($urandom); wdata1 = DW'($urandom);
      lat = $urandom_range(1, 12);
      rd = DW'($urandom);
      exp_w = (rq == 2'b11) ? ~model_last : rq[1];
      exp_rw = exp_w ? rw1 : rw0;
      exp_addr = exp_w ? addr1 : addr0;
      exp_data = exp_w ? wdata1 : wdata0;
      exp_rdata = exp_rw ? rd : model_rdata;
      run_txn(rq, lat, 1'b1, rd, 1'b1);
      checks++; if (ack_val !== (2'b01 << exp_w) || n_start !== 1 || s_cyc !== ack_cyc) begin
        failures++; $display("FAIL rnd%0d_grant got=%b starts=%0d exp=%b 1", i, ack_val, n_start, 2'b01 << exp_w);
      end
      checks++; if ({s_rw, s_addr, s_data} !== {exp_rw, exp_addr, exp_data}) begin
        failures++; $display("FAIL rnd%0d_cmd got=%b/%h/%h exp=%b/%h/%h", i, s_rw, s_addr, s_data, exp_rw, exp_addr, exp_data);
      end
      checks++; if (done_addr !== exp_addr) begin failures++; $display("FAIL rnd%0d_held_addr got=%h exp=%h", i, done_addr, exp_addr); end
      checks++; if (done_val !== (2'b01 << exp_w) || err_o !== 1'b0 || rdata_o !== exp_rdata) begin
        failures++; $display("FAIL rnd%0d_done got=%b err=%b rdata=%h exp=%b 0 %h", i, done_val, err_o, rdata_o, 2'b01 << exp_w, exp_rdata);
      end
      checks++; if (done_cyc !== s_cyc + lat + 1 || overlap !== 1'b0) begin
        failures++; $display("FAIL rnd%0d_timing got=%0d overlap=%b exp=%0d 0", i, done_cyc - s_cyc, overlap, lat + 1);
      end
      model_last = exp_w;
      model_rdata = exp_rdata;
    end
    req = 2'b00;
  endtask

  initial begin
    rst = 1'b1; req = 2'b00; spi_valid = 1'b0; spi_rdata = '0;
    rw0 = 1'b0; rw1 = 1'b0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    test_reset();
    test_single_write();
    test_single_read();
    test_timeout();
    test_back_to_back();
    test_stray_valid();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
